// File: rtl/maxpool_frame_scheduler.sv
// Job-level controller for the StreamingMaxPool kernel: launches one frame at a time over
// ap_ctrl_hs, counts completed frames against a job length and supervises kernel stalls.
module maxpool_frame_scheduler #(
   parameter int FRAME_W = 16,
   parameter int WDT_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [FRAME_W-1:0] cfg_frames,
   input  logic [WDT_W-1:0]   stall_limit,
   input  logic               job_start,
   input  logic               abort,
   output logic               job_busy,
   output logic               job_done,
   output logic               job_error,
   output logic [FRAME_W-1:0] frames_done,
   output logic               ap_start,
   input  logic               ap_ready,
   input  logic               ap_done,
   input  logic               ap_idle,
   input  logic               block_in
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_DONE,
      S_STOP,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] target_q, target_d;
   logic [WDT_W-1:0]   limit_q, limit_d;
   logic [FRAME_W-1:0] frames_q, frames_d;
   logic [WDT_W-1:0]   wdt_q, wdt_d;
   logic               ap_start_q, ap_start_d;
   logic               job_busy_q, job_busy_d;
   logic               job_done_q, job_done_d;
   logic               job_error_q, job_error_d;

   logic [WDT_W-1:0]   wdt_inc;
   logic [FRAME_W-1:0] frames_inc;
   logic               fault;
   logic               can_count;
   logic               done_evt;
   logic               counted;

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      limit_d     = limit_q;
      frames_d    = frames_q;
      wdt_d       = wdt_q;
      job_error_d = job_error_q;
      done_evt    = 1'b0;
      counted     = 1'b0;

      // Saturating stall count; any unblocked cycle restarts the run.
      if (block_in) begin
         wdt_inc = (wdt_q == {WDT_W{1'b1}}) ? wdt_q : wdt_q + WDT_W'(1);
      end else begin
         wdt_inc = '0;
      end
      fault      = (limit_q != '0) && (wdt_inc >= limit_q);
      frames_inc = frames_q + FRAME_W'(1);
      can_count  = (frames_q != target_q);

      case (state_q)
         S_IDLE: begin
            wdt_d = '0;
            if (job_start) begin
               target_d    = cfg_frames;
               limit_d     = stall_limit;
               frames_d    = '0;
               job_error_d = 1'b0;
               state_d     = (cfg_frames == '0) ? S_DONE : S_LAUNCH;
            end
         end

         S_LAUNCH, S_WAIT_DONE: begin
            // A done seen together with ready in LAUNCH completes the frame immediately.
            done_evt = (state_q == S_LAUNCH) ? (ap_ready && ap_done) : ap_done;
            counted  = done_evt && can_count;
            wdt_d    = counted ? '0 : wdt_inc;
            if (counted) begin
               frames_d = frames_inc;
            end
            if (abort || fault) begin
               job_error_d = 1'b1;
               state_d     = S_STOP;
            end else if (counted) begin
               state_d = (frames_inc == target_q) ? S_DONE : S_LAUNCH;
            end else if (state_q == S_LAUNCH && ap_ready) begin
               state_d = S_WAIT_DONE;
            end
         end

         S_STOP: begin
            wdt_d = '0;
            if (ap_done && can_count) begin
               frames_d = frames_inc;
            end
            if (ap_idle) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered images of the next state.
      ap_start_d = (state_d == S_LAUNCH);
      job_busy_d = (state_d != S_IDLE);
      job_done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         target_q    <= '0;
         limit_q     <= '0;
         frames_q    <= '0;
         wdt_q       <= '0;
         ap_start_q  <= 1'b0;
         job_busy_q  <= 1'b0;
         job_done_q  <= 1'b0;
         job_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         limit_q     <= limit_d;
         frames_q    <= frames_d;
         wdt_q       <= wdt_d;
         ap_start_q  <= ap_start_d;
         job_busy_q  <= job_busy_d;
         job_done_q  <= job_done_d;
         job_error_q <= job_error_d;
      end
   end

   assign ap_start    = ap_start_q;
   assign job_busy    = job_busy_q;
   assign job_done    = job_done_q;
   assign job_error   = job_error_q;
   assign frames_done = frames_q;

endmodule
